// File: rtl/rob_commit_unit.sv
// Reorder-buffer allocation and in-order retirement to the register file or memory.
// Define ROB_STORE_EN to build the store path (mem_* outputs and the STORE_WAIT state).
module rob_commit_unit #(
   parameter int WORD_SIZE = 32,
   parameter int RB_SIZE   = 8,
   parameter int RB_INDEX  = 4,
   parameter int REG_INDEX = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          alloc_req,
   input  logic [REG_INDEX-1:0]          alloc_dest,
   input  logic                          alloc_is_store,
   output logic                          alloc_ready,
   output logic [RB_INDEX-1:0]           alloc_index,
   input  logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
   input  logic [RB_SIZE-1:0]            CDB_data_valid,
   input  logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
   output logic                          reg_we,
   output logic [REG_INDEX-1:0]          reg_waddr,
   output logic [WORD_SIZE-1:0]          reg_wdata,
   output logic                          mem_we,
   output logic [WORD_SIZE-1:0]          mem_addr,
   output logic [WORD_SIZE-1:0]          mem_wdata,
   input  logic                          mem_ack,
   output logic [RB_INDEX-1:0]           commit_index,
   output logic [RB_INDEX-1:0]           count
);

   localparam int PTR_W = $clog2(RB_SIZE);
   localparam logic [RB_INDEX-1:0] NULL_IDX = '1;
   localparam logic [1:0] E_FREE = 2'd0, E_ALLOC = 2'd1, E_EXEC = 2'd2, E_DONE = 2'd3;

   // state      | meaning
   // S_IDLE     | retire a DONE head entry, or launch its store
   // S_STORE_WAIT | store request held until mem_ack
`ifdef ROB_STORE_EN
   typedef enum logic {S_IDLE, S_STORE_WAIT} state_t;
`else
   typedef enum logic {S_IDLE} state_t;
`endif
   state_t state, state_next;

   logic [1:0]           ent_state [RB_SIZE];
   logic [REG_INDEX-1:0] ent_dest  [RB_SIZE];
   logic [PTR_W-1:0]     head, tail;
   logic                 accept, head_done, retire_reg, retire_store, retire;
   logic [WORD_SIZE-1:0] head_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RB_SIZE - 1)) ? '0 : p + 1'b1;
   endfunction

   assign alloc_ready = (count < RB_INDEX'(RB_SIZE));
   assign alloc_index = alloc_ready ? RB_INDEX'(tail) : NULL_IDX;
   assign accept      = alloc_req && alloc_ready && !flush;
   assign head_done   = (ent_state[head] == E_DONE);
   assign head_data   = CDB_data_data[int'(head)*WORD_SIZE +: WORD_SIZE];
   assign retire      = retire_reg | retire_store;

`ifdef ROB_STORE_EN
   logic [RB_SIZE-1:0]   ent_store;
   logic                 head_store, issue_store;
   logic [WORD_SIZE-1:0] head_addr;
   assign head_store = ent_store[head];
   assign head_addr  = CDB_data_addr[int'(head)*WORD_SIZE +: WORD_SIZE];
`else
   logic unused_store_inputs;
   assign unused_store_inputs = ^{alloc_is_store, CDB_data_addr, mem_ack};
   assign mem_we    = 1'b0;
   assign mem_addr  = '0;
   assign mem_wdata = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
`ifdef ROB_STORE_EN
         S_IDLE:       if (head_done && head_store) state_next = S_STORE_WAIT;
         S_STORE_WAIT: if (mem_ack) state_next = S_IDLE;
`endif
         default:      state_next = S_IDLE;
      endcase
      if (flush) state_next = S_IDLE;
   end

   always_comb begin
      retire_reg   = 1'b0;
      retire_store = 1'b0;
`ifdef ROB_STORE_EN
      issue_store  = 1'b0;
`endif
      if (!flush) begin
         case (state)
            S_IDLE: begin
               if (head_done) begin
`ifdef ROB_STORE_EN
                  if (head_store) issue_store = 1'b1;
                  else
`endif
                  retire_reg = 1'b1;
               end
            end
`ifdef ROB_STORE_EN
            S_STORE_WAIT: retire_store = mem_ack;
`endif
            default: ;
         endcase
      end
   end

   // Entry lifecycle; an entry must see valid low before high, so a stale valid never completes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RB_SIZE; i++) ent_state[i] <= E_FREE;
      end else begin
         for (int i = 0; i < RB_SIZE; i++) begin
            if (flush) begin
               ent_state[i] <= E_FREE;
            end else begin
               case (ent_state[i])
                  E_FREE:  if (accept && tail == PTR_W'(i)) ent_state[i] <= E_ALLOC;
                  E_ALLOC: if (!CDB_data_valid[i]) ent_state[i] <= E_EXEC;
                  E_EXEC:  if (CDB_data_valid[i]) ent_state[i] <= E_DONE;
                  default: if (retire && head == PTR_W'(i)) ent_state[i] <= E_FREE;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         ent_dest[tail] <= alloc_dest;
`ifdef ROB_STORE_EN
         ent_store[tail] <= alloc_is_store;
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         reg_we       <= 1'b0;
         reg_waddr    <= '0;
         reg_wdata    <= '0;
         commit_index <= NULL_IDX;
`ifdef ROB_STORE_EN
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
`endif
      end else begin
         reg_we       <= 1'b0;
         commit_index <= NULL_IDX;
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
`ifdef ROB_STORE_EN
            mem_we <= 1'b0;
`endif
         end else begin
            if (accept) tail <= ptr_inc(tail);
            if (retire) begin
               head         <= ptr_inc(head);
               commit_index <= RB_INDEX'(head);
            end
            case ({accept, retire})
               2'b10:   count <= count + RB_INDEX'(1);
               2'b01:   count <= count - RB_INDEX'(1);
               default: ;
            endcase
            if (retire_reg) begin
               reg_we    <= 1'b1;
               reg_waddr <= ent_dest[head];
               reg_wdata <= head_data;
            end
`ifdef ROB_STORE_EN
            if (issue_store) begin
               mem_we    <= 1'b1;
               mem_addr  <= head_addr;
               mem_wdata <= head_data;
            end else if (retire_store) begin
               mem_we <= 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: doc/rob_commit_unit.md
# rob_commit_unit

In-order retirement end of the common data bus. The CDB data controller latches functional-unit results into per-entry reorder-buffer slots (data, valid, store address). This block allocates those slots to issuing instructions, watches the per-slot valid bits, and retires the head entry in program order to the register file or to memory. It owns the head/tail pointers and occupancy count. The CDB registers themselves live in the controller.

## Interface
- WORD_SIZE, 32, data/address width
- RB_SIZE, 8, number of reorder-buffer entries
- RB_INDEX, 4, entry index width; the all-ones value is NULL (no entry), so RB_SIZE < 2**RB_INDEX
- REG_INDEX, 5, architectural register index width

- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous squash of all entries
- alloc_req  in  1  issue stage requests an entry this cycle
- alloc_dest  in  REG_INDEX  destination register (ignored for stores)
- alloc_is_store  in  1  entry is a store
- alloc_ready  out  1  combinational: count < RB_SIZE
- alloc_index  out  RB_INDEX  combinational: tail pointer when alloc_ready, else NULL
- CDB_data_data  in  WORD_SIZE*RB_SIZE  per-entry result, entry i at bits [i*WORD_SIZE +: WORD_SIZE]
- CDB_data_valid  in  RB_SIZE  per-entry valid
- CDB_data_addr  in  RB_SIZE*WORD_SIZE  per-entry store address
- reg_we, reg_waddr, reg_wdata  out  1/REG_INDEX/WORD_SIZE  registered register-file write
- mem_we, mem_addr, mem_wdata  out  1/WORD_SIZE/WORD_SIZE  registered store request
- mem_ack  in  1  memory accepted the store
- commit_index  out  RB_INDEX  entry retired this cycle; NULL otherwise
- count  out  RB_INDEX  occupied entries

## Operation
- Per-entry state: FREE -> ALLOC -> EXEC -> DONE -> FREE.
  - FREE -> ALLOC: allocation of that entry is accepted.
  - ALLOC -> EXEC: first posedge that samples CDB_data_valid[i]==0. Functional units clear valid when they begin executing.
  - EXEC -> DONE: first posedge that samples CDB_data_valid[i]==1.
  - A valid bit left high from the slot's previous occupant never marks the new entry DONE.
- Allocation is accepted when alloc_req && alloc_ready && !flush.
  - On accept: record dest and is_store at tail; tail <= tail+1, wrapping from RB_SIZE-1 to 0; count increments.
- Commit FSM, states IDLE and STORE_WAIT.
  - IDLE with head entry DONE and not a store:
    - reg_we=1, reg_waddr=dest, reg_wdata=CDB_data_data[head], commit_index=head.
    - Entry goes FREE; head advances with wrap; count decrements.
  - IDLE with head entry DONE and a store:
    - mem_we=1, mem_addr=CDB_data_addr[head], mem_wdata=CDB_data_data[head]; go to STORE_WAIT.
  - STORE_WAIT: hold mem_we and its operands until a posedge samples mem_ack=1. Then drop mem_we, set commit_index=head, free the entry, advance head, return to IDLE.
  - At most one retirement per cycle.
- Allocation and retirement in the same cycle: count is unchanged. alloc_ready uses the pre-update count, so a full buffer does not accept an allocation in the cycle it retires.
- Empty (count==0): the FSM stays IDLE and no commit outputs are asserted.
- flush has priority over alloc and commit:
  - All entries go FREE; head, tail and count go to 0; FSM goes to IDLE.
  - reg_we and mem_we drop at that edge, including an in-flight store.
  - A mem_ack in the flush cycle is ignored.
- Register index 0 writes are still issued; the register file discards them.

## Timing
- The controller updates CDB on negedge, and this block samples on the following posedge (half-cycle setup).
- Latency: valid rises at negedge n → entry DONE at posedge n → reg_we high from posedge n+1 for exactly one cycle.
- A store needs at least 2 cycles: mem_we is asserted at posedge n+1, and with mem_ack=1 in that cycle it retires at posedge n+2.
- Back-to-back DONE register entries retire one per cycle with no bubble.
- Reset values: all entries FREE; head=tail=count=0; FSM IDLE; reg_we=0, mem_we=0; reg_waddr, reg_wdata, mem_addr, mem_wdata all 0; commit_index=NULL.
- Asserting reset mid-store drops mem_we immediately (asynchronous).

## Configuration
- ROB_STORE_EN defined: store path as described.
- ROB_STORE_EN undefined:
  - alloc_is_store and CDB_data_addr are ignored; mem_we, mem_addr and mem_wdata are constant 0.
  - STORE_WAIT does not exist; every DONE head retires as a register write.

## Test plan
- Reset, then allocate 3 entries with dest 1,2,3: alloc_index 0,1,2 and count=3. Drive valid low then high with data 0xA,0xB,0xC in order. Expect reg_we on three consecutive cycles with (1,0xA),(2,0xB),(3,0xC).
- Out-of-order completion: entry 2 DONE before entry 0. Expect no reg_we until entry 0 DONE, then retirement of 0,1,2 in order.
- Stale valid: slot 0 valid held at 1 from its prior use across a new allocation. Expect no retire until valid has gone 0 then 1.
- Fill 8 entries: alloc_ready=0, alloc_index=NULL. Wrap: after head retires, the next allocation gets index 0 and tail wraps.
- Store, ROB_STORE_EN defined: addr 0x100, data 0x55, mem_ack held low 3 cycles. Expect mem_we held for 4 cycles, then retirement. With ROB_STORE_EN undefined, the same entry produces reg_we with data 0x55.
- Flush during STORE_WAIT with 4 entries live: the next cycle shows mem_we=0, count=0, alloc_index=0.
